// File: rtl/el2_dccm_init_ctl_if.sv
// Core-to-DCCM bus bundle: core strobes, addresses and write data in, core_ready
// back, and the memory-side copy of the same signals out of the controller.
interface el2_dccm_init_ctl_if #(
  parameter int DCCM_BITS        = 16,
  parameter int DCCM_FDATA_WIDTH = 39
);
  logic                        core_wren;
  logic                        core_rden;
  logic [DCCM_BITS-1:0]        core_wr_addr_lo;
  logic [DCCM_BITS-1:0]        core_wr_addr_hi;
  logic [DCCM_BITS-1:0]        core_rd_addr_lo;
  logic [DCCM_BITS-1:0]        core_rd_addr_hi;
  logic [DCCM_FDATA_WIDTH-1:0] core_wr_data_lo;
  logic [DCCM_FDATA_WIDTH-1:0] core_wr_data_hi;
  logic                        core_ready;

  logic                        mem_wren;
  logic                        mem_rden;
  logic [DCCM_BITS-1:0]        mem_wr_addr_lo;
  logic [DCCM_BITS-1:0]        mem_wr_addr_hi;
  logic [DCCM_BITS-1:0]        mem_rd_addr_lo;
  logic [DCCM_BITS-1:0]        mem_rd_addr_hi;
  logic [DCCM_FDATA_WIDTH-1:0] mem_wr_data_lo;
  logic [DCCM_FDATA_WIDTH-1:0] mem_wr_data_hi;

  // master = LSU/core side; slave = the init controller sitting in front of the memory
  modport master (
    output core_wren, core_rden,
    output core_wr_addr_lo, core_wr_addr_hi, core_rd_addr_lo, core_rd_addr_hi,
    output core_wr_data_lo, core_wr_data_hi,
    input  core_ready,
    input  mem_wren, mem_rden,
    input  mem_wr_addr_lo, mem_wr_addr_hi, mem_rd_addr_lo, mem_rd_addr_hi,
    input  mem_wr_data_lo, mem_wr_data_hi
  );

  modport slave (
    input  core_wren, core_rden,
    input  core_wr_addr_lo, core_wr_addr_hi, core_rd_addr_lo, core_rd_addr_hi,
    input  core_wr_data_lo, core_wr_data_hi,
    output core_ready,
    output mem_wren, mem_rden,
    output mem_wr_addr_lo, mem_wr_addr_hi, mem_rd_addr_lo, mem_rd_addr_hi,
    output mem_wr_data_lo, mem_wr_data_hi
  );
endinterface

// File: rtl/el2_dccm_init_ctl.sv
// DCCM front-end: walks the whole DCCM writing INIT_DATA two words per cycle,
// then passes core traffic straight through to the memory port.
module el2_dccm_init_ctl #(
  parameter int                          DCCM_BITS        = 16,
  parameter int                          DCCM_FDATA_WIDTH = 39,
  parameter logic [DCCM_FDATA_WIDTH-1:0] INIT_DATA        = '0,
  parameter bit                          AUTO_INIT        = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_l,
  input  logic                 init_req,
  output logic                 init_busy,
  output logic                 init_done,
  output logic                 req_dropped,
  el2_dccm_init_ctl_if.slave   bus
);

  // One count per 8-byte pair of words; DCCM_BITS must be >= 4 so this is >= 1 bit.
  localparam int CNT_W = DCCM_BITS - 3;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    INIT  = 2'd1,
    READY = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             init_done_q, init_done_d;
  logic             req_dropped_q, req_dropped_d;
  logic             fwd;
  logic             walking;

  assign fwd            = (state_q == READY);
  assign walking        = (state_q == INIT);
  assign bus.core_ready = fwd;
  assign init_busy      = walking;
  assign init_done      = init_done_q;
  assign req_dropped    = req_dropped_q;

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of the others; blocking here would create ordering races.
  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      init_done_q   <= 1'b0;
      req_dropped_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      init_done_q   <= init_done_d;
      req_dropped_q <= req_dropped_d;
    end
  end

  // NOTE: every signal driven in this block gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d       = state_q;
    cnt_d         = '0;
    init_done_d   = init_done_q;
    req_dropped_d = req_dropped_q | ((bus.core_wren | bus.core_rden) & ~fwd);

    unique case (state_q)
      IDLE: begin
        if (AUTO_INIT || init_req) begin
          state_d     = INIT;
          init_done_d = 1'b0;
        end
      end
      INIT: begin
        // init_req is deliberately ignored here: the walk never restarts.
        cnt_d = cnt_q + CNT_W'(1);
        if (&cnt_q) begin
          state_d     = READY;
          init_done_d = 1'b1;
        end
      end
      READY: begin
        if (init_req) begin
          state_d     = INIT;
          init_done_d = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.mem_wren       = 1'b0;
    bus.mem_rden       = 1'b0;
    bus.mem_wr_addr_lo = '0;
    bus.mem_wr_addr_hi = '0;
    bus.mem_rd_addr_lo = '0;
    bus.mem_rd_addr_hi = '0;
    bus.mem_wr_data_lo = '0;
    bus.mem_wr_data_hi = '0;

    if (walking) begin
      bus.mem_wren       = 1'b1;
      bus.mem_wr_addr_lo = {cnt_q, 3'b000};
      bus.mem_wr_addr_hi = {cnt_q, 3'b100};
      bus.mem_wr_data_lo = INIT_DATA;
      bus.mem_wr_data_hi = INIT_DATA;
    end else if (fwd) begin
      bus.mem_wren       = bus.core_wren;
      bus.mem_rden       = bus.core_rden;
      bus.mem_wr_addr_lo = bus.core_wr_addr_lo;
      bus.mem_wr_addr_hi = bus.core_wr_addr_hi;
      bus.mem_rd_addr_lo = bus.core_rd_addr_lo;
      bus.mem_rd_addr_hi = bus.core_rd_addr_hi;
      bus.mem_wr_data_lo = bus.core_wr_data_lo;
      bus.mem_wr_data_hi = bus.core_wr_data_hi;
    end
  end

endmodule

// File: tb/tb_el2_dccm_init_ctl.sv
// Scoreboard bench: two controllers (auto-init and request-init) on a 64-byte DCCM;
// stimulus queues expected memory transactions, negedge monitors pop and compare.
module tb_el2_dccm_init_ctl;

  localparam int DB = 6;
  localparam int FW = 39;
  localparam int N  = 1 << (DB - 3);
  localparam logic [FW-1:0] IDATA = '0;

  typedef struct packed {
    logic          wr;
    logic          rd;
    logic [DB-1:0] wa_lo;
    logic [DB-1:0] wa_hi;
    logic [DB-1:0] ra_lo;
    logic [DB-1:0] ra_hi;
    logic [FW-1:0] wd_lo;
    logic [FW-1:0] wd_hi;
    logic [31:0]   cyc;
  } txn_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;
  txn_t q_a[$];
  txn_t q_b[$];

  logic rst_a, rst_b, req_a, req_b;
  logic busy_a, done_a, drop_a, busy_b, done_b, drop_b;

  el2_dccm_init_ctl_if #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(FW)) if_a ();
  el2_dccm_init_ctl_if #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(FW)) if_b ();

  el2_dccm_init_ctl #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(FW), .INIT_DATA(IDATA), .AUTO_INIT(1'b1)) u_a (
    .clk(clk), .rst_l(rst_a), .init_req(req_a),
    .init_busy(busy_a), .init_done(done_a), .req_dropped(drop_a), .bus(if_a.slave)
  );

  el2_dccm_init_ctl #(.DCCM_BITS(DB), .DCCM_FDATA_WIDTH(FW), .INIT_DATA(IDATA), .AUTO_INIT(1'b0)) u_b (
    .clk(clk), .rst_l(rst_b), .init_req(req_b),
    .init_busy(busy_b), .init_done(done_b), .req_dropped(drop_b), .bus(if_b.slave)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_txn(input string name, input txn_t act, input txn_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got wr=%0b rd=%0b wa=%0h/%0h ra=%0h/%0h wd=%0h/%0h cyc=%0d, expected wr=%0b rd=%0b wa=%0h/%0h ra=%0h/%0h wd=%0h/%0h cyc=%0d",
               name, act.wr, act.rd, act.wa_lo, act.wa_hi, act.ra_lo, act.ra_hi, act.wd_lo, act.wd_hi, act.cyc,
               exp.wr, exp.rd, exp.wa_lo, exp.wa_hi, exp.ra_lo, exp.ra_hi, exp.wd_lo, exp.wd_hi, exp.cyc);
    end
  endtask

  // Reference model of a walk: word pair i lives at byte 8*i and 8*i+4.
  task automatic push_walk(input bit to_b, input int first_cyc, input int count);
    txn_t t;
    for (int i = 0; i < count; i++) begin
      t       = '0;
      t.wr    = 1'b1;
      t.wa_lo = DB'(8 * i);
      t.wa_hi = DB'(8 * i + 4);
      t.wd_lo = IDATA;
      t.wd_hi = IDATA;
      t.cyc   = 32'(first_cyc + i);
      if (to_b) q_b.push_back(t);
      else      q_a.push_back(t);
    end
  endtask

  // Drives core side of A with random address/data; returns what a pass-through must show.
  task automatic drive_a(input bit wr, input bit rd, output txn_t t);
    if_a.core_wren       = wr;
    if_a.core_rden       = rd;
    if_a.core_wr_addr_lo = DB'($urandom);
    if_a.core_wr_addr_hi = DB'($urandom);
    if_a.core_rd_addr_lo = DB'($urandom);
    if_a.core_rd_addr_hi = DB'($urandom);
    if_a.core_wr_data_lo = {7'($urandom), 32'($urandom)};
    if_a.core_wr_data_hi = {7'($urandom), 32'($urandom)};
    t = '{wr, rd, if_a.core_wr_addr_lo, if_a.core_wr_addr_hi, if_a.core_rd_addr_lo,
          if_a.core_rd_addr_hi, if_a.core_wr_data_lo, if_a.core_wr_data_hi, 32'(cyc)};
  endtask

  task automatic drive_b(input bit wr, input bit rd);
    if_b.core_wren       = wr;
    if_b.core_rden       = rd;
    if_b.core_wr_addr_lo = DB'($urandom);
    if_b.core_wr_addr_hi = DB'($urandom);
    if_b.core_rd_addr_lo = DB'($urandom);
    if_b.core_rd_addr_hi = DB'($urandom);
    if_b.core_wr_data_lo = {7'($urandom), 32'($urandom)};
    if_b.core_wr_data_hi = {7'($urandom), 32'($urandom)};
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon_a
    txn_t act;
    if (if_a.mem_wren || if_a.mem_rden) begin
      act = '{if_a.mem_wren, if_a.mem_rden, if_a.mem_wr_addr_lo, if_a.mem_wr_addr_hi,
              if_a.mem_rd_addr_lo, if_a.mem_rd_addr_hi, if_a.mem_wr_data_lo, if_a.mem_wr_data_hi, 32'(cyc)};
      if (q_a.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_a_unexpected: got strobe wr=%0b rd=%0b at cyc=%0d, expected none", act.wr, act.rd, cyc);
      end else begin
        check_txn("mem_a", act, q_a.pop_front());
      end
    end
  end

  always @(negedge clk) begin : mon_b
    txn_t act;
    if (if_b.mem_wren || if_b.mem_rden) begin
      act = '{if_b.mem_wren, if_b.mem_rden, if_b.mem_wr_addr_lo, if_b.mem_wr_addr_hi,
              if_b.mem_rd_addr_lo, if_b.mem_rd_addr_hi, if_b.mem_wr_data_lo, if_b.mem_wr_data_hi, 32'(cyc)};
      if (q_b.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL mem_b_unexpected: got strobe wr=%0b rd=%0b at cyc=%0d, expected none", act.wr, act.rd, cyc);
      end else begin
        check_txn("mem_b", act, q_b.pop_front());
      end
    end
  end

  task automatic seq_a();
    txn_t t;
    int   base;
    rst_a = 1'b0;
    req_a = 1'b0;
    drive_a(1'b0, 1'b0, t);
    repeat (3) step();
    check("a_rst_ready", if_a.core_ready, 0);
    check("a_rst_busy",  busy_a, 0);
    check("a_rst_done",  done_a, 0);
    check("a_rst_drop",  drop_a, 0);
    check("a_rst_mem",   {if_a.mem_wren, if_a.mem_rden, if_a.mem_wr_addr_lo, if_a.mem_wr_data_lo}, 0);

    // Auto walk after reset release: writes in cycles 1..N, ready at N+1.
    rst_a = 1'b1;
    base  = cyc;
    push_walk(1'b0, base + 1, N);
    for (int k = 1; k <= N + 1; k++) begin
      step();
      drive_a(1'b0, 1'b0, t);
      if (k == N) check("a_walk_busy_last", {busy_a, if_a.core_ready}, 2'b10);
    end
    check("a_ready_after_walk", {if_a.core_ready, done_a, busy_a}, 3'b110);

    // Random READY traffic, first beat is the directed 0x10 / 5A write.
    for (int i = 0; i < 16; i++) begin
      drive_a(i == 0 ? 1'b1 : 1'($urandom), 1'($urandom), t);
      if (i == 0) begin
        if_a.core_wr_addr_lo = DB'('h10);
        if_a.core_wr_data_lo = FW'('h5A);
        t.wa_lo = DB'('h10);
        t.wd_lo = FW'('h5A);
      end
      if (t.wr || t.rd) q_a.push_back(t);
      step();
    end
    check("a_no_drop_in_ready", drop_a, 0);

    // init_req together with a read: read forwarded, walk starts next cycle.
    base  = cyc;
    req_a = 1'b1;
    drive_a(1'b0, 1'b1, t);
    q_a.push_back(t);
    push_walk(1'b0, base + 1, N);
    for (int k = 1; k <= N + 1; k++) begin
      step();
      req_a = (k == 4);      // mid-walk request at cnt=3 must be ignored
      drive_a(k == 2, 1'b0, t);
      if (k == 1) check("a_rereq_ready_drop", {if_a.core_ready, busy_a, done_a}, 3'b010);
      if (k == 3) check("a_req_dropped", drop_a, 1);
      if (k == N) check("a_rewalk_not_ready", if_a.core_ready, 0);
    end
    check("a_rewalk_done", {if_a.core_ready, done_a}, 2'b11);

    // Reset asserted mid-walk at cnt=5, then a clean restart from address 0.
    base  = cyc;
    req_a = 1'b1;
    drive_a(1'b0, 1'b0, t);
    push_walk(1'b0, base + 1, 6);
    for (int k = 1; k <= 6; k++) begin
      step();
      req_a = 1'b0;
      drive_a(1'b0, 1'b0, t);
    end
    @(negedge clk);
    #1;
    rst_a = 1'b0;
    #1;
    check("a_async_rst_outs", {if_a.core_ready, busy_a, done_a, drop_a, if_a.mem_wren, if_a.mem_wr_addr_lo}, 0);
    step();
    rst_a = 1'b1;
    base  = cyc;
    push_walk(1'b0, base + 1, N);
    for (int k = 1; k <= N + 1; k++) begin
      step();
      drive_a(1'b0, 1'b0, t);
    end
    check("a_restart_ready", {if_a.core_ready, done_a}, 2'b11);
  endtask

  task automatic seq_b();
    int base;
    rst_b = 1'b0;
    req_b = 1'b0;
    drive_b(1'b0, 1'b0);
    repeat (2) step();
    rst_b = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      drive_b(1'b0, k == 10);
      check("b_idle_quiet", {if_b.mem_wren, if_b.mem_rden, busy_b, if_b.core_ready, if_b.mem_rd_addr_lo, if_b.mem_wr_addr_lo}, 0);
      if (k == 11) check("b_idle_drop", drop_b, 1);
    end
    step();
    base  = cyc;
    req_b = 1'b1;
    drive_b(1'b0, 1'b0);
    push_walk(1'b1, base + 1, N);
    for (int k = 1; k <= N + 1; k++) begin
      step();
      req_b = 1'b0;
      drive_b(1'b0, 1'b0);
      if (k == 1) check("b_walk_started", busy_b, 1);
    end
    check("b_ready_after_walk", {if_b.core_ready, done_b, busy_b}, 3'b110);
  endtask

  initial begin
    fork
      seq_a();
      seq_b();
    join
    step();
    check("a_queue_drained", q_a.size(), 0);
    check("b_queue_drained", q_b.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/el2_dccm_init_ctl.md
# el2_dccm_init_ctl

Parametrised DCCM front-end controller between the LSU DCCM control path and the banked DCCM memory (el2_lsu_dccm_mem). After reset, or on request, it walks the whole DCCM address space and writes a programmable initialisation word, with ECC pre-computed, into every location. While it does this it holds the core off with a ready handshake. Once initialisation completes it multiplexes core read/write traffic straight through to the memory port.

## Interface
Parameters:
- DCCM_BITS, 16, DCCM byte-address width; word count = 2^(DCCM_BITS-2).
- DCCM_FDATA_WIDTH, 39, stored word width (32 data + 7 ECC).
- INIT_DATA, 39'h0, word written to every location; must carry valid ECC.
- AUTO_INIT, 1, 1 = initialise automatically after reset; 0 = wait for init_req.

Ports:
- clk  in  1  core clock; the only clock.
- rst_l  in  1  reset, asynchronous, active-low.
- init_req  in  1  single-cycle request to (re)initialise the DCCM.
- core_wren  in  1  core write strobe.
- core_rden  in  1  core read strobe.
- core_wr_addr_lo / core_wr_addr_hi  in  DCCM_BITS  core write addresses.
- core_rd_addr_lo / core_rd_addr_hi  in  DCCM_BITS  core read addresses.
- core_wr_data_lo / core_wr_data_hi  in  DCCM_FDATA_WIDTH  core write data.
- core_ready  out  1  high when core strobes are forwarded to memory.
- init_busy  out  1  high while the walk is in progress.
- init_done  out  1  sticky; set when a walk completes.
- req_dropped  out  1  sticky; core strobe seen while core_ready=0.
- mem_wren / mem_rden  out  1  memory strobes.
- mem_wr_addr_lo / mem_wr_addr_hi / mem_rd_addr_lo / mem_rd_addr_hi  out  DCCM_BITS  memory addresses.
- mem_wr_data_lo / mem_wr_data_hi  out  DCCM_FDATA_WIDTH  memory write data.

## Operation
- FSM states: IDLE, INIT, READY. The reset state is IDLE.
- IDLE:
  - with AUTO_INIT=1, go to INIT on the first clk edge with rst_l high.
  - with AUTO_INIT=0, go to INIT on init_req.
  - mem_wren=mem_rden=0 in IDLE; core_ready=0.
- INIT:
  - counter cnt has width DCCM_BITS-3 and starts at 0. Each cycle writes two words.
  - mem_wren=1, mem_wr_addr_lo = {cnt,3'b000}, mem_wr_addr_hi = {cnt,3'b100}.
  - Both data outputs = INIT_DATA; mem_rden=0.
  - cnt increments each cycle. At cnt = all-ones, go to READY next cycle; cnt wraps to 0.
  - init_req received in INIT is ignored and does not restart the walk.
- READY:
  - all mem_* outputs equal the corresponding core_* inputs, combinational pass-through; core_ready=1.
  - init_req: go to INIT next cycle. A core strobe in the same cycle as init_req is still forwarded.
- Dropping: core_wren or core_rden asserted while core_ready=0 is not forwarded and sets req_dropped.
- init_done: set on the INIT->READY transition; cleared on entry to INIT.
- init_busy = (state==INIT).
- When not forwarding, address/data outputs drive 0.

## Timing
- Reset values: state IDLE, cnt 0, core_ready 0, init_busy 0, init_done 0, req_dropped 0, all mem_* outputs 0.
- Assertion of rst_l low at any point aborts the walk immediately (asynchronous) and returns to IDLE. A partial init leaves the memory contents undefined.
- AUTO_INIT=1: edge 1 after reset release enters INIT. Writes occupy cycles 1..N, where N = 2^(DCCM_BITS-3). core_ready rises at cycle N+1.
- Walk latency from init_req in READY: core_ready drops 1 cycle later. It returns N+1 cycles after init_req.
- core_ready, init_busy and init_done are registered-state decodes with no combinational path from core_* inputs.
- The mem path from core_* inputs to mem_* outputs in READY has zero latency.
- req_dropped is registered; it is visible the cycle after the offending strobe.
- DCCM_BITS must be at least 4.

## Test plan
- DCCM_BITS=6, AUTO_INIT=1, INIT_DATA=39'h0:
  - release reset -> exactly 8 write cycles, lo addresses 0x00,0x08..0x38 and hi addresses 0x04..0x3C.
  - core_ready=1 at cycle 9; init_done=1.
- AUTO_INIT=0: hold 20 cycles after reset -> mem_wren stays 0; pulse init_req -> walk starts next cycle.
- In READY, core_wren with wr_addr_lo=0x10 and data 39'h5A -> mem_wren=1, address 0x10, data 39'h5A in the same cycle.
- init_req together with core_rden in READY:
  - the read is forwarded that cycle, then core_ready=0.
  - a core_wren two cycles later is not forwarded and req_dropped=1.
- init_req pulsed mid-walk (cnt=3) -> no restart; walk completes at the original cycle.
- rst_l low at cnt=5:
  - all outputs go to reset values immediately.
  - after release, the walk restarts from address 0.
